// File: rtl/periph_interco_pkg.sv
// Shared types and helpers for the peripheral interconnect slave arbiter.
// Provides the arbiter FSM states and the round-robin first-one search.
package periph_interco_pkg;

    localparam int MAX_MASTER = 64;

    typedef logic [5:0] master_idx_t;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // First set bit of req[n-1:0] scanning from ptr upward, wrapping mod n.
    function automatic master_idx_t rr_first_one(
        input logic [MAX_MASTER-1:0] req,
        input master_idx_t           ptr,
        input int unsigned           n
    );
        master_idx_t result;
        master_idx_t idx;
        logic        found;
        int unsigned j;
        result = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < MAX_MASTER; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                idx = master_idx_t'(j);
                if (!found && req[idx]) begin
                    found  = 1'b1;
                    result = idx;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/periph_id_fifo.sv
// In-order tracker of granted master indices awaiting a slave response.
// Separate occupancy counter avoids any full/empty pointer ambiguity.
module periph_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/periph_slave_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port among N_MASTER PEs.
// Winner is locked while the slave stalls; responses routed in grant order.
module periph_slave_rr_arbiter
    import periph_interco_pkg::*;
#(
    parameter int N_MASTER        = 16,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 2,
    localparam int LOG_MASTER     = $clog2(N_MASTER),
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_MASTER-1:0]                  data_req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
    input  logic [N_MASTER-1:0]                  data_wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
    output logic [N_MASTER-1:0]                  data_gnt_o,
    output logic                                 data_req_o,
    output logic [ADDR_WIDTH-1:0]                data_add_o,
    output logic                                 data_wen_o,
    output logic [DATA_WIDTH-1:0]                data_wdata_o,
    output logic [BE_WIDTH-1:0]                  data_be_o,
    input  logic                                 data_gnt_i,
    input  logic                                 data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                data_r_rdata_i,
    input  logic                                 data_r_opc_i,
    output logic [N_MASTER-1:0]                  data_r_valid_o,
    output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
    output logic                                 data_r_opc_o,
    output logic [CNT_W-1:0]                     outstanding_o,
    output logic                                 resp_err_o
);

    typedef logic [LOG_MASTER-1:0] idx_t;

    arb_state_e            state;
    arb_state_e            state_nxt;
    idx_t                  rr_ptr;
    idx_t                  locked_idx;
    idx_t                  rr_winner;
    idx_t                  winner;
    idx_t                  head_idx;
    logic [MAX_MASTER-1:0] req_ext;
    logic                  lock_hold;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  resp_err;
    logic [CNT_W-1:0]      count;

    periph_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (LOG_MASTER)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (winner),
        .rdata (head_idx),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        req_ext                 = '0;
        req_ext[N_MASTER-1:0]   = data_req_i;
        rr_winner = idx_t'(rr_first_one(req_ext, master_idx_t'(rr_ptr), N_MASTER));
        // A locked winner is released only if its own request drops.
        lock_hold = (state == LOCK) && data_req_i[locked_idx];
        winner    = lock_hold ? locked_idx : rr_winner;

        data_req_o = !rst && !full && (|data_req_i);
        push       = data_req_o && data_gnt_i;
        pop        = !rst && data_r_valid_i && !empty;

        data_gnt_o = '0;
        if (push) begin
            data_gnt_o[winner] = 1'b1;
        end

        data_add_o   = '0;
        data_wen_o   = 1'b0;
        data_wdata_o = '0;
        data_be_o    = '0;
        if (data_req_o) begin
            data_add_o   = data_add_i[winner];
            data_wen_o   = data_wen_i[winner];
            data_wdata_o = data_wdata_i[winner];
            data_be_o    = data_be_i[winner];
        end

        data_r_valid_o = '0;
        if (pop) begin
            data_r_valid_o[head_idx] = 1'b1;
        end
        data_r_rdata_o = rst ? '0 : data_r_rdata_i;
        data_r_opc_o   = !rst && data_r_opc_i;
        outstanding_o  = rst ? '0 : count;
        resp_err_o     = !rst && resp_err;

        state_nxt = state;
        if (!full) begin
            if (push) begin
                state_nxt = ARB;
            end else if (data_req_o) begin
                state_nxt = LOCK;
            end else begin
                state_nxt = ARB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            rr_ptr     <= '0;
            locked_idx <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (data_req_o && !data_gnt_i) begin
                locked_idx <= winner;
            end
            if (push) begin
                rr_ptr <= (winner == idx_t'(N_MASTER - 1)) ? '0 : winner + idx_t'(1);
            end
            if (data_r_valid_i && empty) begin
                resp_err <= 1'b1;
            end
        end
    end

endmodule
